// File: rtl/memory_arbiter_ctrl_pkg.sv
// Shared types for the CPU memory arbiter: word type, RAM handshake state,
// arbiter FSM state and the latched request payload.
package memory_arbiter_ctrl_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned TIMEOUT_DEF = 16;
    localparam int unsigned CNT_W_DEF   = 5;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2,
        FAULT = 2'd3
    } arb_state_t;

    // Request captured in IDLE and replayed to the RAM until it retires
    typedef struct packed {
        logic  write;
        word_t addr;
        word_t data;
    } req_t;

endpackage

// File: rtl/memory_arbiter_ctrl_wait_timer.sv
// Saturating wait counter with synchronous clear; expire flags LIMIT-1 reached.
module memory_arbiter_ctrl_wait_timer #(
    parameter int unsigned LIMIT = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    assign expire = (count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/memory_arbiter_ctrl.sv
// Serialises instruction and data requests onto the single RAM port, with
// data priority, hit suppression on stale requests, timeout and sticky fault.
module memory_arbiter_ctrl
    import memory_arbiter_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      ihit,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dhit,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      mem_fault,
    output logic      busy
);

    arb_state_t state, state_next;
    req_t       req, req_next;
    logic       in_flight;
    logic       expire;
    logic       d_match;
    logic       i_match;

    assign in_flight = (state == DATA) || (state == INSTR);
    assign mem_fault = (state == FAULT);
    assign busy      = (state != IDLE);

    // Requester must still be asking for the same thing when the RAM answers
    assign d_match = (req.write ? dWEN : dREN) && (daddr == req.addr);
    assign i_match = iREN && (iaddr == req.addr);

    memory_arbiter_ctrl_wait_timer #(
        .LIMIT (TIMEOUT),
        .CNT_W (CNT_W)
    ) u_wait_timer (
        .clk    (CLK),
        .rst_n  (nRST),
        .clear  (!in_flight),
        .enable (in_flight),
        .expire (expire)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            req   <= '0;
        end else begin
            state <= state_next;
            req   <= req_next;
        end
    end

    always_comb begin
        state_next = state;
        req_next   = req;
        ihit       = 1'b0;
        dhit       = 1'b0;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;

        case (state)
            IDLE: begin
                if (dREN || dWEN) begin
                    state_next = DATA;
                    req_next   = '{write: dWEN, addr: daddr, data: dstore};
                end else if (iREN) begin
                    state_next = INSTR;
                    req_next   = '{write: 1'b0, addr: iaddr, data: '0};
                end
            end

            DATA: begin
                ramaddr  = req.addr;
                ramstore = req.data;
                ramREN   = !req.write;
                ramWEN   = req.write;
                if (ramstate == ACCESS) begin
                    state_next = IDLE;
                    dhit       = d_match;
                    if (d_match && !req.write) begin
                        dload = ramload;
                    end
                end else if ((ramstate == ERROR) || expire) begin
                    state_next = FAULT;
                end
            end

            INSTR: begin
                ramaddr = req.addr;
                ramREN  = 1'b1;
                if (ramstate == ACCESS) begin
                    state_next = IDLE;
                    ihit       = i_match;
                    if (i_match) begin
                        iload = ramload;
                    end
                end else if ((ramstate == ERROR) || expire) begin
                    state_next = FAULT;
                end
            end

            FAULT: begin
                state_next = FAULT;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter_ctrl.sv
// Directed bench for memory_arbiter_ctrl: cycle vector table plus hand-written
// timeout, error and asynchronous-reset sequences.
module tb_memory_arbiter_ctrl;
    import memory_arbiter_ctrl_pkg::*;

    typedef struct packed {
        logic      iren;
        word_t     iaddr;
        logic      dren;
        logic      dwen;
        word_t     daddr;
        word_t     dstore;
        ramstate_t rs;
        word_t     ramload;
    } in_t;

    typedef struct packed {
        logic  ihit;
        logic  dhit;
        logic  ren;
        logic  wen;
        logic  busy;
        logic  fault;
        word_t iload;
        word_t dload;
        word_t addr;
        word_t store;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic      CLK;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    logic      ihit, dhit, ramREN, ramWEN, mem_fault, busy;
    word_t     iload, dload, ramaddr, ramstore;
    ramstate_t ramstate;

    int tests;
    int fails;
    int both_cnt;
    int dhit_cnt;

    localparam int unsigned NVEC = 22;
    vec_t vecs [NVEC];

    memory_arbiter_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .ihit      (ihit),
        .iload     (iload),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dhit      (dhit),
        .dload     (dload),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate),
        .mem_fault (mem_fault),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction and data hits must never coincide
    always @(negedge CLK) begin
        #4;
        if (ihit && dhit) both_cnt++;
    end

    function automatic in_t mk_in(input logic ir, input word_t ia, input logic dr,
                                  input logic dw, input word_t da, input word_t ds,
                                  input ramstate_t rs, input word_t rl);
        return '{iren: ir, iaddr: ia, dren: dr, dwen: dw, daddr: da, dstore: ds,
                 rs: rs, ramload: rl};
    endfunction

    function automatic out_t mk_out(input logic ih, input logic dh, input logic rr,
                                    input logic rw, input logic bz, input logic ft,
                                    input word_t il, input word_t dl, input word_t ad,
                                    input word_t st);
        return '{ihit: ih, dhit: dh, ren: rr, wen: rw, busy: bz, fault: ft,
                 iload: il, dload: dl, addr: ad, store: st};
    endfunction

    function automatic out_t sample();
        return '{ihit: ihit, dhit: dhit, ren: ramREN, wen: ramWEN, busy: busy,
                 fault: mem_fault, iload: iload, dload: dload, addr: ramaddr,
                 store: ramstore};
    endfunction

    task automatic apply(input in_t v);
        iREN     = v.iren;
        iaddr    = v.iaddr;
        dREN     = v.dren;
        dWEN     = v.dwen;
        daddr    = v.daddr;
        dstore   = v.dstore;
        ramstate = v.rs;
        ramload  = v.ramload;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = sample();
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got ihit=%b dhit=%b ren=%b wen=%b busy=%b fault=%b iload=%h dload=%h addr=%h store=%h, expected ihit=%b dhit=%b ren=%b wen=%b busy=%b fault=%b iload=%h dload=%h addr=%h store=%h",
                     name, act.ihit, act.dhit, act.ren, act.wen, act.busy, act.fault,
                     act.iload, act.dload, act.addr, act.store,
                     exp.ihit, exp.dhit, exp.ren, exp.wen, exp.busy, exp.fault,
                     exp.iload, exp.dload, exp.addr, exp.store);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        out_t zero;
        in_t  idle_in;
        tests    = 0;
        fails    = 0;
        both_cnt = 0;
        dhit_cnt = 0;
        zero     = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_in  = mk_in(0, 0, 0, 0, 0, 0, FREE, 0);

        // Instruction fetch with two BUSY cycles
        vecs[0]  = '{mk_in(1, 32'h40, 0, 0, 0, 0, FREE, 0), zero};
        vecs[1]  = '{mk_in(1, 32'h40, 0, 0, 0, 0, BUSY, 0), mk_out(0, 0, 1, 0, 1, 0, 0, 0, 32'h40, 0)};
        vecs[2]  = '{mk_in(1, 32'h40, 0, 0, 0, 0, BUSY, 0), mk_out(0, 0, 1, 0, 1, 0, 0, 0, 32'h40, 0)};
        vecs[3]  = '{mk_in(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h3C01_0010),
                     mk_out(1, 0, 1, 0, 1, 0, 32'h3C01_0010, 0, 32'h40, 0)};
        vecs[4]  = '{idle_in, zero};
        // Simultaneous write and fetch: write wins, fetch follows after bubble
        vecs[5]  = '{mk_in(1, 32'h80, 0, 1, 32'h100, 32'hDEAD_BEEF, FREE, 0), zero};
        vecs[6]  = '{mk_in(1, 32'h80, 0, 1, 32'h100, 32'hDEAD_BEEF, ACCESS, 32'h1234_5678),
                     mk_out(0, 1, 0, 1, 1, 0, 0, 0, 32'h100, 32'hDEAD_BEEF)};
        vecs[7]  = '{mk_in(1, 32'h80, 0, 0, 0, 0, FREE, 0), zero};
        vecs[8]  = '{mk_in(1, 32'h80, 0, 0, 0, 0, ACCESS, 32'hAABB_CCDD),
                     mk_out(1, 0, 1, 0, 1, 0, 32'hAABB_CCDD, 0, 32'h80, 0)};
        vecs[9]  = '{idle_in, zero};
        // Data address changes mid-flight: stale hit suppressed, new one served
        vecs[10] = '{mk_in(0, 0, 1, 0, 32'h200, 0, FREE, 0), zero};
        vecs[11] = '{mk_in(0, 0, 1, 0, 32'h204, 0, BUSY, 0), mk_out(0, 0, 1, 0, 1, 0, 0, 0, 32'h200, 0)};
        vecs[12] = '{mk_in(0, 0, 1, 0, 32'h204, 0, ACCESS, 32'h1111_2222),
                     mk_out(0, 0, 1, 0, 1, 0, 0, 0, 32'h200, 0)};
        vecs[13] = '{mk_in(0, 0, 1, 0, 32'h204, 0, FREE, 0), zero};
        vecs[14] = '{mk_in(0, 0, 1, 0, 32'h204, 0, ACCESS, 32'h5555_6666),
                     mk_out(0, 1, 1, 0, 1, 0, 0, 32'h5555_6666, 32'h204, 0)};
        vecs[15] = '{idle_in, zero};
        // dREN and dWEN together behave as a write
        vecs[16] = '{mk_in(0, 0, 1, 1, 32'h300, 32'hCAFE_F00D, FREE, 0), zero};
        vecs[17] = '{mk_in(0, 0, 1, 1, 32'h300, 32'hCAFE_F00D, ACCESS, 32'h99),
                     mk_out(0, 1, 0, 1, 1, 0, 0, 0, 32'h300, 32'hCAFE_F00D)};
        vecs[18] = '{idle_in, zero};
        // Instruction address changes mid-flight: ihit suppressed
        vecs[19] = '{mk_in(1, 32'h600, 0, 0, 0, 0, FREE, 0), zero};
        vecs[20] = '{mk_in(1, 32'h604, 0, 0, 0, 0, ACCESS, 32'h77),
                     mk_out(0, 0, 1, 0, 1, 0, 0, 0, 32'h600, 0)};
        vecs[21] = '{idle_in, zero};

        nRST = 1'b0;
        apply(idle_in);
        #1;
        check("reset_state", zero);
        @(negedge CLK);
        nRST = 1'b1;

        for (int k = 0; k < int'(NVEC); k++) begin
            @(negedge CLK);
            apply(vecs[k].i);
            #1;
            check($sformatf("vec%0d", k), vecs[k].o);
        end

        // Timeout: 16 BUSY cycles in DATA, then sticky FAULT
        @(negedge CLK);
        apply(mk_in(0, 0, 1, 0, 32'h400, 0, BUSY, 0));
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            #1;
            check($sformatf("timeout_wait%0d", c), mk_out(0, 0, 1, 0, 1, 0, 0, 0, 32'h400, 0));
        end
        @(negedge CLK);
        #1;
        check("timeout_fault", mk_out(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        apply(mk_in(1, 32'h400, 1, 0, 32'h400, 0, ACCESS, 32'h1));
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            #1;
            check($sformatf("fault_sticky%0d", c), mk_out(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        end
        nRST = 1'b0;
        #1;
        check("fault_reset", zero);
        @(negedge CLK);
        apply(idle_in);
        nRST = 1'b1;

        // RAM error during instruction fetch
        @(negedge CLK);
        apply(mk_in(1, 32'h44, 0, 0, 0, 0, FREE, 0));
        @(negedge CLK);
        apply(mk_in(1, 32'h44, 0, 0, 0, 0, ERROR, 0));
        #1;
        check("err_instr", mk_out(0, 0, 1, 0, 1, 0, 0, 0, 32'h44, 0));
        @(negedge CLK);
        apply(mk_in(1, 32'h44, 0, 0, 0, 0, ACCESS, 32'h1));
        #1;
        check("err_fault", mk_out(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        nRST = 1'b0;
        @(negedge CLK);
        apply(idle_in);
        nRST = 1'b1;

        // Asynchronous reset while DATA waits on BUSY
        @(negedge CLK);
        apply(mk_in(0, 0, 1, 0, 32'h500, 0, FREE, 0));
        @(negedge CLK);
        apply(mk_in(0, 0, 1, 0, 32'h500, 0, BUSY, 0));
        #1;
        check("rst_busy", mk_out(0, 0, 1, 0, 1, 0, 0, 0, 32'h500, 0));
        #1;
        nRST = 1'b0;
        #1;
        check("rst_async", zero);
        @(negedge CLK);
        nRST = 1'b1;
        apply(mk_in(0, 0, 1, 0, 32'h504, 0, ACCESS, 32'h0BAD_F00D));
        for (int c = 0; c < 6; c++) begin
            #1;
            if (dhit) dhit_cnt++;
            if (c == 1) begin
                check("fresh_read", mk_out(0, 1, 1, 0, 1, 0, 0, 32'h0BAD_F00D, 32'h504, 0));
                @(posedge CLK);
                #1;
                apply(idle_in);
            end
            @(negedge CLK);
        end
        check_int("one_dhit", dhit_cnt, 1);
        check_int("no_dual_hit", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
